sync_rx_buffer: RTL

Capture buffer that sits directly downstream of the synchronizer block, entirely in the `clk` domain. It turns the synchronized strobe level into single-cycle write events and captures the synchronized data word on each event. Captured words are held in a small show-ahead FIFO until a local consumer pops them, which decouples the consumer from strobe arrival timing. Words arriving while the FIFO is full are dropped and counted.

---
 rtl/sync_rx_buffer.sv | 77 +++++++
 1 files changed

// File: rtl/sync_rx_buffer.sv
// sync_rx_buffer: turns a synchronized strobe into write events and queues the captured words in a show-ahead FIFO.
//   clk, rst_n (async, active-low)
//   sync_stb, sync_data : synchronized strobe level and its data word
//   rd_en               : consumer pop request
//   rd_data             : head entry, 0 while empty
//   empty, full, count  : FIFO occupancy status
//   edge_seen           : one-cycle pulse per detected strobe rise
//   ovf_cnt             : saturating count of words dropped while full
//   Optional: define SYNC_RX_DEDUP_EN to discard a word equal to the last one written.
module sync_rx_buffer #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sync_stb,
    input  logic [DW-1:0]              sync_data,
    input  logic                       rd_en,
    output logic [DW-1:0]              rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       edge_seen,
    output logic [7:0]                 ovf_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          stb_q, edge_det, dup, push_req, push, pop, drop;
`ifdef SYNC_RX_DEDUP_EN
    logic [DW-1:0] last_word;
    logic          last_vld;
    assign dup = last_vld && (sync_data == last_word);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_word <= '0;
            last_vld  <= 1'b0;
        end else if (push) begin
            last_word <= sync_data;
            last_vld  <= 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif
    assign edge_det = sync_stb & ~stb_q;
    assign push_req = edge_det & ~dup;
    assign pop      = rd_en & ~empty;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a word when rd_en is high.
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~rd_en;
    assign empty    = count == '0;
    assign full     = count == CW'(DEPTH);
    assign rd_data  = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= sync_data;
    end
    // stb_q resets high so a strobe already high at reset release is not taken as a rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stb_q     <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            edge_seen <= 1'b0;
            ovf_cnt   <= '0;
        end else begin
            stb_q     <= sync_stb;
            edge_seen <= edge_det;
            wr_ptr    <= push ? wr_ptr + PW'(1) : wr_ptr;
            rd_ptr    <= pop ? rd_ptr + PW'(1) : rd_ptr;
            count     <= count + CW'(push) - CW'(pop);
            ovf_cnt   <= (drop && ovf_cnt != 8'hFF) ? ovf_cnt + 8'd1 : ovf_cnt;
        end
    end
endmodule
